// File: rtl/alu_operand_regfile.sv
// Operand register file for the ALU: two forwarding read ports, one write-back
// port, a per-register busy scoreboard with stall, and a registered debug read port.
module alu_operand_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              stall,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_r [NREG];
    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   busy_nxt_s;
    logic [DATA_W-1:0] dbg_data_r;
    logic              fwd1_s;
    logic              fwd2_s;
    logic              s1_s;
    logic              s2_s;
    logic              stall_s;
    logic              issue_ok_s;
    logic              wr_ok_s;

    assign dbg_data = dbg_data_r;
    assign stall    = stall_s;

    // Forward-hit and per-source stall detection
    always_comb begin
        fwd1_s = wb_en && (wb_addr == rs1_addr);
        fwd2_s = wb_en && (wb_addr == rs2_addr);
        s1_s   = (rs1_addr != {ADDR_W{1'b0}}) && busy_r[rs1_addr] && !fwd1_s;
        s2_s   = (rs2_addr != {ADDR_W{1'b0}}) && busy_r[rs2_addr] && !fwd2_s;
        if (!rst_n) begin
            stall_s = 1'b0;
        end else begin
            stall_s = s1_s || s2_s;
        end
        issue_ok_s = issue_en && !stall_s && (issue_rd != {ADDR_W{1'b0}});
        wr_ok_s    = wb_en && (wb_addr != {ADDR_W{1'b0}});
    end

    // Operand A read mux with write-back forwarding
    always_comb begin
        if (!rst_n) begin
            A = {DATA_W{1'b0}};
        end else if (rs1_addr == {ADDR_W{1'b0}}) begin
            A = {DATA_W{1'b0}};
        end else if (fwd1_s) begin
            A = wb_data;
        end else begin
            A = regs_r[rs1_addr];
        end
    end

    // Operand B read mux with write-back forwarding
    always_comb begin
        if (!rst_n) begin
            B = {DATA_W{1'b0}};
        end else if (rs2_addr == {ADDR_W{1'b0}}) begin
            B = {DATA_W{1'b0}};
        end else if (fwd2_s) begin
            B = wb_data;
        end else begin
            B = regs_r[rs2_addr];
        end
    end

    // Next busy vector: write-back clears first so a same-edge issue wins
    always_comb begin
        busy_nxt_s = busy_r;
        if (wb_en) begin
            busy_nxt_s[wb_addr] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (issue_ok_s) begin
            busy_nxt_s[issue_rd] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Register array, scoreboard and debug read state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            busy_r     <= {NREG{1'b0}};
            dbg_data_r <= {DATA_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                regs_r[wb_addr] <= wb_data;
            end
            busy_r <= busy_nxt_s;
            // Debug reads the array before this edge's write lands
            dbg_data_r <= (dbg_addr == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[dbg_addr];
        end
    end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Scoreboard bench for alu_operand_regfile: directed scenarios plus a
// randomized run checked against a reference model of the register file.
module tb_alu_operand_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, wb_addr, issue_rd, dbg_addr;
    logic [31:0] A, B, wb_data, dbg_data;
    logic        wb_en, issue_en, stall;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] exp;

    logic [31:0] m_reg [32];
    logic [31:0] m_busy;
    logic [31:0] m_dbg;

    alu_operand_regfile #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .A(A), .B(B),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .stall(stall),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic logic m_src_stall(input logic [4:0] a);
        return (a != 5'd0) && m_busy[a] && !(wb_en && wb_addr == a);
    endfunction

    function automatic logic m_stall();
        return rst_n && (m_src_stall(rs1_addr) || m_src_stall(rs2_addr));
    endfunction

    // Apply one rising edge to the model, then advance the DUT past it
    task automatic step();
        logic st;
        st = m_stall();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
            m_busy = 32'h0;
            m_dbg  = 32'h0;
        end else begin
            m_dbg = (dbg_addr == 5'd0) ? 32'h0 : m_reg[dbg_addr];
            if (wb_en && wb_addr != 5'd0) m_reg[wb_addr] = wb_data;
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (issue_en && !st && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            m_busy[0] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd6;
        step(); step();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        got = A; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL rst_A got %h want %h", got, exp); end
        got = B; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL rst_B got %h want %h", got, exp); end
        got = {31'h0, stall}; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL rst_stall got %h want %h", got, exp); end
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            exp_q.push_back(32'h0);
            step();
            got = dbg_data; exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL rst_dbg[%0d] got %h want %h", a, got, exp); end
        end
        // A write aimed at r0 must neither forward nor land
        rs1_addr = 5'd0; dbg_addr = 5'd0;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
        exp_q.push_back(32'h0);
        #1;
        got = A; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL r0_fwd got %h want %h", got, exp); end
        step();
        wb_en = 1'b0;
        exp_q.push_back(32'h0);
        step();
        got = dbg_data; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL r0_dbg got %h want %h", got, exp); end
    endtask

    task automatic test_write_read();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_00F0;
        step();
        wb_en = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd5; dbg_addr = 5'd5;
        exp_q.push_back(32'h0000_00F0); exp_q.push_back(32'h0000_00F0);
        #1;
        got = A; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL wr_A got %h want %h", got, exp); end
        got = B; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL wr_B got %h want %h", got, exp); end
        exp_q.push_back(32'h0000_00F0);
        step();
        got = dbg_data; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL wr_dbg got %h want %h", got, exp); end
    endtask

    task automatic test_forwarding();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1111_1111;
        step();
        wb_data = 32'h2222_2222; rs2_addr = 5'd7; dbg_addr = 5'd7;
        exp_q.push_back(32'h2222_2222);
        #1;
        got = B; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL fwd_B got %h want %h", got, exp); end
        exp_q.push_back(32'h1111_1111);
        step();
        wb_en = 1'b0;
        got = dbg_data; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL fwd_dbg_old got %h want %h", got, exp); end
        exp_q.push_back(32'h2222_2222);
        step();
        got = dbg_data; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL fwd_dbg_new got %h want %h", got, exp); end
    endtask

    task automatic test_stall();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        issue_en = 1'b1; issue_rd = 5'd9;
        step();
        rs1_addr = 5'd9; issue_rd = 5'd11;
        // Issue to r11 held while stalled: must not take effect
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(32'h1);
            #1;
            got = {31'h0, stall}; exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL stall_hold[%0d] got %h want %h", c, got, exp); end
            step();
        end
        issue_en = 1'b0; rs1_addr = 5'd11;
        exp_q.push_back(32'h0);
        #1;
        got = {31'h0, stall}; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL stall_no_accept got %h want %h", got, exp); end
        rs1_addr = 5'd9; issue_en = 1'b1;
        step();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0ABC;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0000_0ABC);
        #1;
        got = {31'h0, stall}; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL stall_wb got %h want %h", got, exp); end
        got = A; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL stall_wb_A got %h want %h", got, exp); end
        step();
        wb_en = 1'b0; issue_en = 1'b0; rs1_addr = 5'd11;
        exp_q.push_back(32'h1);
        #1;
        got = {31'h0, stall}; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL stall_late_accept got %h want %h", got, exp); end
        rs1_addr = 5'd9;
        exp_q.push_back(32'h0);
        #1;
        got = {31'h0, stall}; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL stall_cleared got %h want %h", got, exp); end
        wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'h0;
        step();
        wb_en = 1'b0;
    endtask

    task automatic test_set_clear();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        issue_en = 1'b1; issue_rd = 5'd4;
        step();
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_0044;
        step();
        wb_en = 1'b0; issue_en = 1'b0; rs1_addr = 5'd4;
        exp_q.push_back(32'h1); exp_q.push_back(32'h0000_0044);
        #1;
        got = {31'h0, stall}; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL setclr_stall got %h want %h", got, exp); end
        got = A; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL setclr_A got %h want %h", got, exp); end
        wb_en = 1'b1; wb_data = 32'h0000_0045;
        step();
        wb_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h5;
        issue_en = 1'b1; issue_rd = 5'd3;
        step();
        wb_en = 1'b0; issue_en = 1'b0; rs1_addr = 5'd3;
        exp_q.push_back(32'h1);
        #1;
        got = {31'h0, stall}; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL mid_busy got %h want %h", got, exp); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        got = A; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL mid_A got %h want %h", got, exp); end
        got = {31'h0, stall}; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL mid_stall got %h want %h", got, exp); end
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h7;
        step();
        wb_en = 1'b0;
        exp_q.push_back(32'h7);
        #1;
        got = A; exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL mid_rewrite got %h want %h", got, exp); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rst_n    = ($urandom_range(39, 0) != 0);
            rs1_addr = 5'($urandom_range(7, 0));
            rs2_addr = 5'($urandom_range(7, 0));
            wb_en    = ($urandom_range(1, 0) == 1);
            wb_addr  = 5'($urandom_range(7, 0));
            wb_data  = $urandom();
            issue_en = ($urandom_range(2, 0) == 0);
            issue_rd = 5'($urandom_range(7, 0));
            dbg_addr = 5'($urandom_range(7, 0));
            exp_q.push_back(m_read(rs1_addr));
            exp_q.push_back(m_read(rs2_addr));
            exp_q.push_back({31'h0, m_stall()});
            #1;
            got = A; exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL rnd_A[%0d] got %h want %h", c, got, exp); end
            got = B; exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL rnd_B[%0d] got %h want %h", c, got, exp); end
            got = {31'h0, stall}; exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL rnd_stall[%0d] got %h want %h", c, got, exp); end
            step();
            exp_q.push_back(m_dbg);
            got = dbg_data; exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL rnd_dbg[%0d] got %h want %h", c, got, exp); end
        end
        rst_n = 1'b1; wb_en = 1'b0; issue_en = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        issue_en = 1'b0; issue_rd = 5'd0; dbg_addr = 5'd0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_busy = 32'h0; m_dbg = 32'h0;
        test_reset();
        test_write_read();
        test_forwarding();
        test_stall();
        test_set_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
- Register file that sits on both sides of the ALU datapath.
- Sources the ALU operands A and B from two read ports.
- Receives the ALU result C on the write-back port.
- Carries a per-register busy scoreboard and a stall output so the pipeline CPU cannot read operands that a multi-cycle op has not yet written.

Parameters:
- DATA_W, 32, width of each register and of the A/B/C datapath.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers (must equal 2**ADDR_W); register 0 is hardwired zero.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rs1_addr  in  ADDR_W  source register for operand A.
- rs2_addr  in  ADDR_W  source register for operand B.
- A  out  DATA_W  operand A to ALU (combinational).
- B  out  DATA_W  operand B to ALU (combinational).
- wb_en  in  1  write-back strobe for the ALU result.
- wb_addr  in  ADDR_W  write-back destination.
- wb_data  in  DATA_W  ALU result C.
- issue_en  in  1  marks issue of an op that will write issue_rd later.
- issue_rd  in  ADDR_W  destination of the issued op.
- stall  out  1  high when either source is busy and not being forwarded this cycle.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  registered debug read data.

Behaviour:
- Reset (rst_n low at a rising edge):
  - All registers are cleared to 0, all busy bits are cleared to 0, and dbg_data is cleared to 0.
  - While rst_n is low, A, B and stall are forced to 0.
  - wb_en and issue_en are ignored in any cycle where rst_n is low.
- Write:
  - On a rising edge with wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data.
  - Writes to register 0 are dropped.
- Read (combinational, zero latency):
  - A = 0 if rs1_addr==0.
  - Otherwise A = wb_data if wb_en && wb_addr==rs1_addr (same-cycle write-to-read forwarding).
  - Otherwise A = reg[rs1_addr].
  - B follows the same rules using rs2_addr.
- Scoreboard:
  - busy[0] is constantly 0.
  - At a rising edge, busy[wb_addr] is cleared when wb_en=1.
  - At a rising edge, busy[issue_rd] is set when the issue is accepted (issue_en=1, stall=0, issue_rd!=0).
  - If the same register is both cleared and set in one edge, set wins; the new in-flight op owns the register.
  - An issue_en that arrives while stall=1 is not accepted and has no effect; the issuer must hold issue_en until stall is low.
- Stall:
  - stall = s1 | s2.
  - s1 = (rs1_addr!=0) && busy[rs1_addr] && !(wb_en && wb_addr==rs1_addr).
  - s2 is the same expression using rs2_addr.
  - A source being written back in the current cycle is forwarded and does not stall.
- Debug port:
  - dbg_data <= (dbg_addr==0) ? 0 : reg[dbg_addr] on every non-reset edge, giving 1-cycle latency.
  - The debug port does not forward wb_data; a write and a debug read of the same address in the same edge return the old value.
- Reset mid-operation: a synchronous reset while busy bits are set clears them; any later wb_en from the aborted op is treated as an ordinary write.
- Widths: no arithmetic is performed; addresses are compared at full ADDR_W width, and data passes through unmodified.

Test Plan:
1. Reset and zero register:
   - Hold rst_n=0 for 2 cycles, then release.
   - Required: A=B=0, stall=0, dbg_data=0 for dbg_addr=0..31.
   - Then write 32'hDEADBEEF to r0; rs1_addr=0 must give A=0.
2. Write then read:
   - wb_en=1, wb_addr=5, wb_data=32'h0000_00F0, then rs1_addr=5, rs2_addr=5 on the next cycle.
   - Required: A=B=32'h0000_00F0.
   - Setting dbg_addr=5 must give dbg_data=32'h0000_00F0 one cycle later.
3. Forwarding:
   - r7 holds 32'h1111_1111. In one cycle drive wb_en=1, wb_addr=7, wb_data=32'h2222_2222 with rs2_addr=7.
   - Required: B=32'h2222_2222 in that same cycle, and dbg_data for addr 7 is 32'h1111_1111 at the next edge.
4. Scoreboard stall:
   - Issue with issue_rd=9, then set rs1_addr=9.
   - Required: stall=1 until the cycle with wb_en=1, wb_addr=9, wb_data=32'h0000_0ABC.
   - In that cycle stall=0 and A=32'h0000_0ABC.
   - A second issue_en held during the stall is accepted only once stall drops.
5. Simultaneous set/clear:
   - At one edge drive wb_en=1, wb_addr=4 together with an accepted issue_en, issue_rd=4.
   - Required: busy[4]=1 afterwards, and rs1_addr=4 stalls.
6. Reset mid-operation:
   - busy[3]=1 and r3=32'h5, then pulse rst_n=0 for one edge.
   - Required: rs1_addr=3 gives A=0, stall=0.
   - A later wb_en to r3 with 32'h7 reads back 32'h7.
